sudoku_game_ctrl: RTL and testbench

Parametrised top-level game controller for the Sudoku datapath. It sequences difficulty selection, board pre-fill from a random cell index, and the input/guess/check loop. It also tracks wrong guesses against a life limit and reports win/loss. It drives the datapath through a `dp_check`/`check_done` handshake and a cell-fill write strobe, replacing the fixed single-mode controller with board size, fill counts and life limit set by parameters.

---
 rtl/sudoku_pkg.sv | 25 ++
 rtl/sudoku_game_ctrl_board_filler.sv | 78 +++++++
 rtl/sudoku_game_ctrl.sv | 136 +++++++++++++
 tb/tb_sudoku_game_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sudoku_pkg.sv
// Shared types and helpers for the Sudoku game controller.
package sudoku_pkg;

    typedef enum logic [3:0] {
        ST_SET_DIFF   = 4'd0,
        ST_FILL_BOARD = 4'd1,
        ST_REG_INP    = 4'd2,
        ST_GUESS      = 4'd3,
        ST_CHECK      = 4'd4,
        ST_WRONG      = 4'd5,
        ST_FIN        = 4'd6,
        ST_LOST       = 4'd7
    } state_e;

    localparam logic [1:0] DIFF_EASY   = 2'b00;
    localparam logic [1:0] DIFF_MED    = 2'b01;
    localparam logic [1:0] DIFF_HARD   = 2'b10;
    localparam logic [1:0] DIFF_EXPERT = 2'b11;

    // Cell index width; never below one bit so tiny boards still elaborate.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sudoku_game_ctrl_board_filler.sv
// Random pre-fill of the board: filters duplicates and out-of-range indices,
// keeps the locked-cell bitmap and emits one write strobe per new cell.
module board_filler
    import sudoku_pkg::*;
#(
    parameter int N_CELLS = 16,
    parameter int IDX_W   = idx_width(N_CELLS)
) (
    input  logic               clka,
    input  logic               restart_n,
    input  logic               start,
    input  logic               active,
    input  logic [IDX_W:0]     target,
    input  logic [IDX_W-1:0]   rand_idx,
    output logic               fill_done,
    output logic               fill_we,
    output logic [IDX_W-1:0]   fill_idx,
    output logic [N_CELLS-1:0] fill_flag
);

    localparam int CNT_W = IDX_W + 1;

    logic [N_CELLS-1:0] hit;
    logic [N_CELLS-1:0] flag_q, flag_d;
    logic [CNT_W-1:0]   count_q, count_d, count_inc;
    logic               fill_we_q, fill_we_d;
    logic [IDX_W-1:0]   fill_idx_q, fill_idx_d;
    logic               free, not_full, accept;

    // One-hot decode of the random index; an out-of-range index decodes to all zeros.
    genvar gi;
    generate
        for (gi = 0; gi < N_CELLS; gi++) begin : g_dec
            assign hit[gi] = (rand_idx == IDX_W'(gi));
        end
    endgenerate

    // Accept a new unlocked cell while the target is not yet reached.
    always_comb begin
        free       = |(hit & ~flag_q);
        not_full   = (count_q != target);
        accept     = active && not_full && free;
        count_inc  = count_q + CNT_W'(1);
        fill_done  = active && (!not_full || (accept && (count_inc == target)));
        flag_d     = flag_q;
        count_d    = count_q;
        fill_idx_d = fill_idx_q;
        fill_we_d  = accept;
        if (start) begin
            flag_d  = '0;
            count_d = '0;
        end else if (accept) begin
            flag_d     = flag_q | hit;
            count_d    = count_inc;
            fill_idx_d = rand_idx;
        end
    end

    // Bitmap, counter and write-port registers.
    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            flag_q     <= '0;
            count_q    <= '0;
            fill_we_q  <= 1'b0;
            fill_idx_q <= '0;
        end else begin
            flag_q     <= flag_d;
            count_q    <= count_d;
            fill_we_q  <= fill_we_d;
            fill_idx_q <= fill_idx_d;
        end
    end

    assign fill_we   = fill_we_q;
    assign fill_idx  = fill_idx_q;
    assign fill_flag = flag_q;

endmodule

// File: rtl/sudoku_game_ctrl.sv
// Game sequencer: difficulty select, board pre-fill, guess/check loop,
// life tracking and win/loss reporting.
module sudoku_game_ctrl
    import sudoku_pkg::*;
#(
    parameter int N_CELLS   = 16,
    parameter int IDX_W     = idx_width(N_CELLS),
    parameter int EASY_FILL = 10,
    parameter int MED_FILL  = 8,
    parameter int HARD_FILL = 6,
    parameter int MAX_WRONG = 3
) (
    input  logic               clka,
    input  logic               restart_n,
    input  logic               enter,
    input  logic [1:0]         difficulty,
    input  logic [IDX_W-1:0]   rand_idx,
    input  logic               check_done,
    input  logic               solved,
    output logic [3:0]         state,
    output logic               dp_check,
    output logic               fill_we,
    output logic [IDX_W-1:0]   fill_idx,
    output logic [N_CELLS-1:0] fill_flag,
    output logic [IDX_W-1:0]   wrong_cnt,
    output logic               won,
    output logic               lost
);

    localparam int CNT_W = IDX_W + 1;

    generate
        if (EASY_FILL > N_CELLS || MED_FILL > N_CELLS || HARD_FILL > N_CELLS) begin : g_fill_err
            $error("fill count exceeds N_CELLS");
        end
        if (MAX_WRONG == 0 || MAX_WRONG >= (1 << IDX_W)) begin : g_wrong_err
            $error("MAX_WRONG must be nonzero and fit in IDX_W");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [IDX_W-1:0] wrong_cnt_q, wrong_cnt_d, wrong_inc;
    logic             dp_check_q, dp_check_d;
    logic             won_q, won_d;
    logic             lost_q, lost_d;
    logic [CNT_W-1:0] target;
    logic [IDX_W-1:0] lives;
    logic             start_fill, fill_done;

    // Fill target and life limit follow the latched mode; both are stable for the whole game.
    always_comb begin
        case (mode_q)
            DIFF_EASY: target = CNT_W'(EASY_FILL);
            DIFF_MED:  target = CNT_W'(MED_FILL);
            default:   target = CNT_W'(HARD_FILL);
        endcase
        lives = (mode_q == DIFF_EXPERT) ? IDX_W'(1) : IDX_W'(MAX_WRONG);
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        wrong_cnt_d = wrong_cnt_q;
        start_fill  = 1'b0;
        wrong_inc   = (wrong_cnt_q == '1) ? wrong_cnt_q : wrong_cnt_q + IDX_W'(1);
        dp_check_d  = (state_q == ST_CHECK);
        won_d       = (state_q == ST_FIN);
        lost_d      = (state_q == ST_LOST);
        case (state_q)
            ST_SET_DIFF: if (enter) begin
                mode_d      = difficulty;
                wrong_cnt_d = '0;
                start_fill  = 1'b1;
                state_d     = ST_FILL_BOARD;
            end
            ST_FILL_BOARD: if (fill_done) state_d = ST_REG_INP;
            ST_REG_INP:    if (enter) state_d = ST_GUESS;
            ST_GUESS:      if (enter) state_d = ST_CHECK;
            ST_CHECK: if (check_done) begin
                if (solved) begin
                    state_d = ST_FIN;
                end else begin
                    wrong_cnt_d = wrong_inc;
                    state_d     = (wrong_inc == lives) ? ST_LOST : ST_WRONG;
                end
            end
            ST_WRONG:       if (enter) state_d = ST_REG_INP;
            ST_FIN, ST_LOST: if (enter) state_d = ST_SET_DIFF;
            default:        state_d = ST_SET_DIFF;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            state_q     <= ST_SET_DIFF;
            mode_q      <= 2'b00;
            wrong_cnt_q <= '0;
            dp_check_q  <= 1'b0;
            won_q       <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            wrong_cnt_q <= wrong_cnt_d;
            dp_check_q  <= dp_check_d;
            won_q       <= won_d;
            lost_q      <= lost_d;
        end
    end

    board_filler #(
        .N_CELLS (N_CELLS),
        .IDX_W   (IDX_W)
    ) u_filler (
        .clka      (clka),
        .restart_n (restart_n),
        .start     (start_fill),
        .active    (state_q == ST_FILL_BOARD),
        .target    (target),
        .rand_idx  (rand_idx),
        .fill_done (fill_done),
        .fill_we   (fill_we),
        .fill_idx  (fill_idx),
        .fill_flag (fill_flag)
    );

    assign state     = state_q;
    assign dp_check  = dp_check_q;
    assign wrong_cnt = wrong_cnt_q;
    assign won       = won_q;
    assign lost      = lost_q;

endmodule

// File: tb/tb_sudoku_game_ctrl.sv
// Randomized bench for sudoku_game_ctrl on a 12-cell board, so 4-bit random
// indices 12..15 exercise the out-of-range filter.
module tb_sudoku_game_ctrl;

    localparam int NC = 12;
    localparam int IW = 4;
    localparam int S_SET = 0, S_FILL = 1, S_REG = 2, S_GUESS = 3;
    localparam int S_CHECK = 4, S_WRONG = 5, S_FIN = 6, S_LOST = 7;

    logic          clka = 1'b0;
    logic          restart_n, enter, check_done, solved;
    logic [1:0]    difficulty;
    logic [IW-1:0] rand_idx;
    logic [3:0]    state;
    logic          dp_check, fill_we, won, lost;
    logic [IW-1:0] fill_idx, wrong_cnt;
    logic [NC-1:0] fill_flag;

    int checks = 0;
    int errors = 0;

    // Reference model: set of locked cells, fill progress, lives and wrong count.
    logic [NC-1:0] seen;
    int target_m, lives_m, wrong_m, fill_cnt;
    int prefix[$];

    sudoku_game_ctrl #(.N_CELLS(NC), .IDX_W(IW)) dut (
        .clka(clka), .restart_n(restart_n), .enter(enter), .difficulty(difficulty),
        .rand_idx(rand_idx), .check_done(check_done), .solved(solved),
        .state(state), .dp_check(dp_check), .fill_we(fill_we), .fill_idx(fill_idx),
        .fill_flag(fill_flag), .wrong_cnt(wrong_cnt), .won(won), .lost(lost)
    );

    always #5 clka = ~clka;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clka);
        @(negedge clka);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_state"}, state, S_SET);
        chk({tag, "_dp_check"}, dp_check, 0);
        chk({tag, "_fill_we"}, fill_we, 0);
        chk({tag, "_fill_idx"}, fill_idx, 0);
        chk({tag, "_fill_flag"}, fill_flag, 0);
        chk({tag, "_wrong_cnt"}, wrong_cnt, 0);
        chk({tag, "_won"}, won, 0);
        chk({tag, "_lost"}, lost, 0);
    endtask

    // Asynchronous reset between clock edges, checked before any edge arrives.
    task automatic reset_now(input string tag);
        #2 restart_n = 1'b0;
        #1 check_reset_vals(tag);
        @(negedge clka);
        restart_n = 1'b1;
        $display("reset %s applied", tag);
    endtask

    task automatic start_game(input logic [1:0] d);
        difficulty = d;
        enter = 1'b1;
        cycle();
        enter = 1'b0;
        target_m = (d == 2'd0) ? 10 : (d == 2'd1) ? 8 : 6;
        lives_m  = (d == 2'd3) ? 1 : 3;
        wrong_m  = 0;
        fill_cnt = 0;
        seen     = '0;
        chk("start_state", state, S_FILL);
        chk("start_flag", fill_flag, 0);
        chk("start_wrong", wrong_cnt, 0);
        chk("start_we", fill_we, 0);
    endtask

    task automatic do_fill(input int stop_after);
        int cyc;
        int r;
        bit acc;
        cyc = 0;
        while (fill_cnt < target_m && cyc < 2000) begin
            if (prefix.size() > 0) r = prefix.pop_front();
            else r = $urandom_range(0, 15);
            rand_idx   = r[IW-1:0];
            enter      = ($urandom_range(0, 3) == 0);
            check_done = $urandom_range(0, 1);
            solved     = $urandom_range(0, 1);
            cycle();
            cyc++;
            acc = 1'b0;
            if (r < NC) acc = !seen[r];
            if (acc) begin
                seen[r] = 1'b1;
                fill_cnt++;
            end
            chk("fill_we", fill_we, acc);
            if (acc) chk("fill_idx", fill_idx, r);
            chk("fill_flag", fill_flag, seen);
            chk("fill_state", state, (fill_cnt == target_m) ? S_REG : S_FILL);
            if (stop_after > 0 && fill_cnt >= stop_after) break;
        end
        enter = 1'b0;
        check_done = 1'b0;
        solved = 1'b0;
        if (stop_after == 0) begin
            chk("fill_count", fill_cnt, target_m);
            chk("popcount", $countones(fill_flag), target_m);
        end
    endtask

    // A REG_INP cycle with a stray check_done and no enter must change nothing.
    task automatic idle_reg();
        check_done = 1'b1;
        solved = $urandom_range(0, 1);
        rand_idx = IW'($urandom_range(0, 15));
        cycle();
        check_done = 1'b0;
        solved = 1'b0;
        chk("idle_state", state, S_REG);
        chk("idle_we", fill_we, 0);
        chk("idle_flag", fill_flag, seen);
    endtask

    task automatic do_check(input bit sol, input int delay, output int res);
        enter = 1'b1;
        cycle();
        chk("to_guess", state, S_GUESS);
        cycle();
        enter = 1'b0;
        chk("to_check", state, S_CHECK);
        chk("dp_lag", dp_check, 0);
        for (int i = 0; i < delay; i++) begin
            enter = $urandom_range(0, 1);
            cycle();
            chk("check_wait", state, S_CHECK);
            chk("dp_check", dp_check, 1);
        end
        enter = 1'b0;
        check_done = 1'b1;
        solved = sol;
        cycle();
        check_done = 1'b0;
        solved = 1'b0;
        if (sol) begin
            res = S_FIN;
        end else begin
            if (wrong_m < 15) wrong_m++;
            res = (wrong_m == lives_m) ? S_LOST : S_WRONG;
        end
        chk("verdict", state, res);
        chk("wrong_cnt", wrong_cnt, wrong_m);
        chk("dp_hold", dp_check, 1);
        cycle();
        chk("dp_fall", dp_check, 0);
        chk("won", won, res == S_FIN);
        chk("lost", lost, res == S_LOST);
        if (res == S_WRONG) begin
            enter = 1'b1;
            cycle();
            enter = 1'b0;
            chk("retry", state, S_REG);
        end
    endtask

    task automatic end_game(input int res);
        cycle();
        chk("end_hold", state, res);
        enter = 1'b1;
        cycle();
        enter = 1'b0;
        chk("to_set", state, S_SET);
        chk("flag_hold", fill_flag, seen);
        cycle();
        chk("set_idle", state, S_SET);
        chk("won_clr", won, 0);
        chk("lost_clr", lost, 0);
    endtask

    task automatic play(input logic [1:0] d, input logic [7:0] plan);
        int res;
        int k;
        k = 0;
        start_game(d);
        do_fill(0);
        idle_reg();
        res = S_WRONG;
        while (res == S_WRONG && k < 8) begin
            do_check(plan[k], (k == 0) ? 5 : $urandom_range(1, 6), res);
            k++;
        end
        end_game(res);
        $display("game diff=%0d checks=%0d wrong=%0d result=%s", d, k, wrong_m,
                 (res == S_FIN) ? "won" : "lost");
    endtask

    initial begin
        int res;
        restart_n  = 1'b0;
        enter      = 1'b0;
        difficulty = 2'b00;
        rand_idx   = '0;
        check_done = 1'b0;
        solved     = 1'b0;
        #1 check_reset_vals("por");
        @(negedge clka);
        @(negedge clka);
        restart_n = 1'b1;
        cycle();
        chk("idle_set", state, S_SET);

        // Scripted games: easy win, medium loss, hard retry-then-win, expert single life.
        prefix = {0, 0, 3, 14, 5};
        play(2'd0, 8'h01);
        play(2'd1, 8'h00);
        play(2'd2, 8'h02);
        play(2'd3, 8'h00);

        // Reset in the middle of the fill after three writes.
        start_game(2'd0);
        do_fill(3);
        reset_now("mid_fill");
        cycle();
        chk("after_fill_reset", state, S_SET);

        // Reset while a check is outstanding, after one wrong guess.
        start_game(2'd2);
        do_fill(0);
        do_check(1'b0, 2, res);
        enter = 1'b1;
        cycle();
        cycle();
        enter = 1'b0;
        cycle();
        chk("pre_reset_dp", dp_check, 1);
        reset_now("mid_check");
        cycle();
        chk("after_check_reset", state, S_SET);

        // Randomized games.
        for (int g = 0; g < 6; g++) begin
            play(2'($urandom_range(0, 3)), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
